// File: rtl/tick_prescaler_pkg.sv
// tick_prescaler_pkg
// Shared definitions for the tick prescaler and the downstream 2-bit counter
// stage it feeds.
//   state_e         : prescaler FSM state encoding (IDLE, RUN, ONESHOT)
//   TP_DEFAULT_DIV  : divisor loaded at reset (tick period = divisor + 1)
//   TICK_CNT_W      : width of the wrap-around tick tally, kept equal to the
//                     width of the downstream counter it mirrors
package tick_prescaler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_ONESHOT = 2'd2
  } state_e;

  localparam logic [7:0] TP_DEFAULT_DIV = 8'd4;
  localparam int unsigned TICK_CNT_W = 2;

endpackage

// File: rtl/tick_prescaler_div_shadow.sv
// div_shadow_reg
// Single-entry shadow register for divisor updates. A value written through
// the ready/valid port is held here until the owner pulses apply_i, which
// empties the entry. That lets the owner choose the exact edge at which a new
// divisor takes effect.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (entry emptied)
//   wr_valid_i   : write request
//   wr_data_i    : value to store
//   wr_ready_o   : registered; high when the entry is empty
//   apply_i      : consume the stored value (ignored while empty)
//   rd_data_o    : stored value
//   full_o       : entry holds a value not yet applied
//
// Handshake: a transfer happens on a posedge where wr_valid_i && wr_ready_o.
// While wr_ready_o is low, wr_valid_i is ignored and the source must keep it
// asserted until it sees wr_ready_o high again.
module div_shadow_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid_i,
  input  logic [W-1:0] wr_data_i,
  output logic         wr_ready_o,
  input  logic         apply_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (apply_i) full_d = 1'b0;
    end else if (wr_valid_i) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign wr_ready_o = ~full_q;
  assign rd_data_o  = data_q;
  assign full_o     = full_q;

endmodule

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Programmable clock-enable generator. While running it emits a one-cycle
// tick every div_q+1 clocks; a start/stop FSM controls it and a shadowed
// ready/valid port updates the divisor without disturbing a period in flight.
// Optional feature macro: TICK_PRESCALER_ONESHOT_EN adds the oneshot input and
// the ONESHOT state (one tick, then back to IDLE).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : level, sampled in IDLE to begin running (stop has priority)
//   stop       : level, sampled while running to return to IDLE
//   div_valid  : divisor load request
//   div_data   : divisor; tick period = div_data + 1 cycles
//   div_ready  : divisor shadow register empty
//   oneshot    : (macro only) start in ONESHOT instead of RUN
//   tick       : registered single-cycle enable for the downstream counter
//   busy       : FSM is not IDLE
//   tick_cnt   : wrap-around count of ticks issued
//   dbg_state  : current FSM state, for observation only
module tick_prescaler
  import tick_prescaler_pkg::*;
#(
  parameter int unsigned      DIV_W       = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(TP_DEFAULT_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  div_valid,
  input  logic [DIV_W-1:0]      div_data,
  output logic                  div_ready,
`ifdef TICK_PRESCALER_ONESHOT_EN
  input  logic                  oneshot,
`endif
  output logic                  tick,
  output logic                  busy,
  output logic [TICK_CNT_W-1:0] tick_cnt,
  output state_e                dbg_state
);

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick_q, tick_d;
  logic [TICK_CNT_W-1:0] tally_q, tally_d;

  logic [DIV_W-1:0]      shadow_data;
  logic                  shadow_full;
  logic                  apply;
  logic                  terminal;
  logic                  go_oneshot;

`ifdef TICK_PRESCALER_ONESHOT_EN
  assign go_oneshot = oneshot;
`else
  assign go_oneshot = 1'b0;
`endif

  assign terminal = (cnt_q == div_q);

  div_shadow_reg #(
    .W (DIV_W)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (div_valid),
    .wr_data_i  (div_data),
    .wr_ready_o (div_ready),
    .apply_i    (apply),
    .rd_data_o  (shadow_data),
    .full_o     (shadow_full)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    apply   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Nothing is being timed, so a pending divisor can land right away.
        apply = shadow_full;
        if (start && !stop) state_d = go_oneshot ? ST_ONESHOT : ST_RUN;
      end
      ST_RUN, ST_ONESHOT: begin
        if (stop) begin
          // Stop wins even on the terminal count: no tick, and the shadow
          // stays pending until the IDLE edge that follows.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (terminal) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          // The period just finished used the old divisor; swap now.
          apply  = shadow_full;
          if (state_q == ST_ONESHOT) state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    div_d   = div_q;
    tally_d = tally_q;
    if (apply && shadow_full) div_d = shadow_data;
    if (tick_d) tally_d = tally_q + TICK_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DEFAULT_DIV;
      tick_q  <= 1'b0;
      tally_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      tally_q <= tally_d;
    end
  end

  assign tick      = tick_q;
  assign busy      = (state_q != ST_IDLE);
  assign tick_cnt  = tally_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tick_prescaler.sv
module tb_tick_prescaler;
  import tick_prescaler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, div_valid;
  logic [7:0] div_data;
  logic       div_ready, tick, busy;
  logic [1:0] tick_cnt;
  state_e     dbg_state;
`ifdef TICK_PRESCALER_ONESHOT_EN
  logic       oneshot;
`endif

  tick_prescaler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .div_valid (div_valid),
    .div_data  (div_data),
    .div_ready (div_ready),
`ifdef TICK_PRESCALER_ONESHOT_EN
    .oneshot   (oneshot),
`endif
    .tick      (tick),
    .busy      (busy),
    .tick_cnt  (tick_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the absolute edge at which the next tick is due
  // rather than a counter, plus the pending divisor and the tally.
  int         edge_n = 0;
  bit         m_run, m_one, m_pend, m_tick, m_acc;
  int         m_next, m_div, m_pval, m_tally;
  logic [1:0] exp_q[$];

  task automatic model_reset();
    m_run = 0; m_one = 0; m_pend = 0; m_tick = 0; m_acc = 0;
    m_div = 4; m_pval = 0; m_tally = 0; m_next = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    bit os_in;
    os_in = 1'b0;
`ifdef TICK_PRESCALER_ONESHOT_EN
    os_in = oneshot;
`endif
    m_acc = div_valid && !m_pend;
    edge_n++;
    m_tick = 0;
    if (!m_run) begin
      if (m_pend) begin m_div = m_pval; m_pend = 0; end
      if (start && !stop) begin
        m_run  = 1;
        m_one  = os_in;
        m_next = edge_n + m_div + 1;
      end
    end else if (stop) begin
      m_run = 0;
    end else if (edge_n == m_next) begin
      m_tick  = 1;
      m_tally = (m_tally + 1) % 4;
      exp_q.push_back(m_tally[1:0]);
      if (m_pend) begin m_div = m_pval; m_pend = 0; end
      m_next = edge_n + m_div + 1;
      if (m_one) m_run = 0;
    end
    if (m_acc) begin m_pend = 1; m_pval = div_data; end
  endtask

  // scoreboard
  task automatic check_outputs();
    check("tick", tick, m_tick);
    check("busy", busy, m_run);
    check("tick_cnt", tick_cnt, m_tally);
    check("div_ready", div_ready, !m_pend);
    check("dbg_state_busy", dbg_state != ST_IDLE, m_run);
    if (tick) begin
      check("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sb_tally", tick_cnt, exp_q.pop_front());
    end else begin
      exp_q.delete();
    end
  endtask

  // drivers
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    check("rst_tick_cnt", tick_cnt, 0);
    check("rst_div_ready", div_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_div(input logic [7:0] v);
    div_valid = 1'b1;
    div_data  = v;
    cycle();
    div_valid = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  initial begin
    int first, last, seen;
    start = 0; stop = 0; div_valid = 0; div_data = '0;
`ifdef TICK_PRESCALER_ONESHOT_EN
    oneshot = 0;
`endif
    do_reset();

    // default divisor: period 5, first tick 5 edges after start
    start = 1; cycle(); start = 0;
    first = -1; last = -1; seen = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (tick) begin
        if (first < 0) first = i;
        else check("t1_period", i - last, 5);
        last = i;
        seen++;
        if (seen <= 4) check("t1_seq", tick_cnt, seen % 4);
      end
    end
    check("t1_first", first, 5);
    check("t1_count", seen, 4);
    pulse_stop();

    // divisor 0 loaded in IDLE: ready low one cycle, tick every cycle
    load_div(8'd0);
    check("t2_ready_low", div_ready, 0);
    cycle();
    check("t2_ready_back", div_ready, 1);
    start = 1; cycle(); start = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      check("t2_tick", tick, 1);
      check("t2_cnt", tick_cnt, i % 4);
    end
    pulse_stop();

    // mid-period reload: old period completes, then period 2
    load_div(8'd4);
    cycle();
    start = 1; cycle(); start = 0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 3) begin div_valid = 1; div_data = 8'd1; end
      cycle();
      div_valid = 0;
      if (i == 3 || i == 4) check("t3_ready_low", div_ready, 0);
      if (i == 5) check("t3_ready_up", div_ready, 1);
      check("t3_tick", tick, (i == 5 || i == 7 || i == 9 || i == 11));
    end
    pulse_stop();

    // stop beats start; stop on terminal count suppresses tick and reload
    start = 1; stop = 1; cycle(); start = 0; stop = 0;
    check("t4_idle", busy, 0);
    start = 1; cycle(); start = 0;
    load_div(8'd3);
    stop = 1; cycle(); stop = 0;
    check("t4_no_tick", tick, 0);
    check("t4_busy", busy, 0);
    check("t4_pending", div_ready, 0);
    cycle();
    check("t4_applied", div_ready, 1);

    // async reset mid-run with a pending shadow; next run uses default
    start = 1; cycle(); start = 0;
    cycle(); cycle();
    load_div(8'd7);
    #2;
    do_reset();
    start = 1; cycle(); start = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      check("t5_tick", tick, i == 5);
    end
    pulse_stop();

`ifdef TICK_PRESCALER_ONESHOT_EN
    load_div(8'd3);
    cycle();
    oneshot = 1; start = 1; cycle(); oneshot = 0; start = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      check("t6_tick", tick, i == 4);
      check("t6_busy", busy, i < 4);
    end
`endif

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 29) == 0);
`ifdef TICK_PRESCALER_ONESHOT_EN
      oneshot = ($urandom_range(0, 3) == 0);
`endif
      if (!div_valid && $urandom_range(0, 7) == 0) begin
        div_valid = 1'b1;
        div_data  = 8'($urandom_range(0, 6));
      end
      cycle();
      if (m_acc) div_valid = 1'b0;
      if ($urandom_range(0, 499) == 0) begin
        #2;
        div_valid = 1'b0;
        do_reset();
      end
    end
    start = 0; stop = 0; div_valid = 0;

    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
